// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and types for the register-file write-port
//               controller (rf_wb_arbiter) and its grant picker.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Architectural zero register; writes to it are swallowed.
  localparam logic [4:0] REG_ZERO = 5'h0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } rf_wb_state_t;

  typedef enum logic [0:0] {
    SRC_MEM = 1'b0,
    SRC_ALU = 1'b1
  } rf_wb_src_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_pick.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_pick
// Description : Two-way writeback grant picker. Fixed priority (mem over alu)
//               by default; round-robin on contested cycles when the macro
//               RF_WB_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_pick
  import rf_pkg::*;
(
`ifdef RF_WB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       en,         // arbitration allowed this cycle
  input  logic       mem_valid,
  input  logic       alu_valid,
  output logic       mem_ready,
  output logic       alu_ready,
  output logic       xfer,       // a handshake completes at the next edge
  output rf_wb_src_t src         // which requester that handshake belongs to
);

`ifdef RF_WB_RR_EN
  rf_wb_src_t ptr;

  // Pointer flips to the loser only when both requesters compete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRC_MEM;
    end else if (en && mem_valid && alu_valid) begin
      ptr <= (ptr == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end
  end

  // Each ready looks only at the other requester's valid and the pointer.
  always_comb begin
    mem_ready = en && (!alu_valid || (ptr == SRC_MEM));
    alu_ready = en && (!mem_valid || (ptr == SRC_ALU));
  end
`else
  // Mem always wins; alu is served only when mem is not requesting.
  always_comb begin
    mem_ready = en;
    alu_ready = en && !mem_valid;
  end
`endif

  // Both readies can be high only when at most one requester is valid, so at
  // most one transfer happens per cycle.
  always_comb begin
    xfer = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    src  = (alu_valid && alu_ready) ? SRC_ALU : SRC_MEM;
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Single write-port controller for reg_file. Arbitrates ALU and
//               load writebacks over valid/ready and runs a scrub sweep that
//               rewrites x1..x31 with SCRUB_VALUE. Registered output stage.
//               Configuration: define RF_WB_RR_EN for round-robin grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int                DATA_W      = rf_pkg::DATA_W,
  parameter int                ADDR_W      = rf_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] SCRUB_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [ADDR_W-1:0] alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              mem_wb_valid,
  output logic              mem_wb_ready,
  input  logic [ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic              scrub_start,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic              write_reg,
  output logic [ADDR_W-1:0] target_reg,
  output logic [DATA_W-1:0] write_rd_data
);
  import rf_pkg::*;

  localparam logic [0:0]        ST_IDLE  = IDLE;
  localparam logic [0:0]        ST_SCRUB = SCRUB;
  localparam logic [ADDR_W-1:0] RD_ZERO  = ADDR_W'(REG_ZERO);
  localparam logic [4:0]        IDX_LAST = 5'd31;

  logic [0:0] state;
  logic [4:0] idx;
  logic       arb_en;
  logic       xfer;
  rf_wb_src_t src;

  // Arbitration only in IDLE, never in the cycle a scrub is requested, and
  // never while reset is held (readies must read 0 then).
  always_comb begin
    arb_en = (state == ST_IDLE) && !scrub_start && !rst;
  end

  rf_wb_pick u_pick (
`ifdef RF_WB_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .en        (arb_en),
    .mem_valid (mem_wb_valid),
    .alu_valid (alu_wb_valid),
    .mem_ready (mem_wb_ready),
    .alu_ready (alu_wb_ready),
    .xfer      (xfer),
    .src       (src)
  );

  // Scrub sequencer: sweep idx 1..31, pulse done alongside the last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 5'd1;
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scrub_start) begin
            state <= ST_SCRUB;
            idx   <= 5'd1;
          end
        end
        ST_SCRUB: begin
          if (idx == IDX_LAST) begin
            state      <= ST_IDLE;
            idx        <= 5'd1;
            scrub_done <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= 5'd1;
        end
      endcase
    end
  end

  always_comb begin
    scrub_busy = (state == ST_SCRUB);
  end

  // Registered write port: scrub write, accepted request, or idle (enable
  // low, index/data held).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg     <= 1'b0;
      target_reg    <= '0;
      write_rd_data <= '0;
    end else if (state == ST_SCRUB) begin
      write_reg     <= 1'b1;
      target_reg    <= ADDR_W'(idx);
      write_rd_data <= SCRUB_VALUE;
    end else if (xfer) begin
      if (src == SRC_MEM) begin
        write_reg     <= (mem_wb_rd != RD_ZERO);
        target_reg    <= mem_wb_rd;
        write_rd_data <= mem_wb_data;
      end else begin
        write_reg     <= (alu_wb_rd != RD_ZERO);
        target_reg    <= alu_wb_rd;
        write_rd_data <= alu_wb_data;
      end
    end else begin
      write_reg <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Scoreboard bench for rf_wb_arbiter. Stimulus pushes expected
//               writes (with the cycle they must appear in); a monitor pops
//               and compares whenever write_reg is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid, mem_wb_valid, scrub_start;
  logic        alu_wb_ready, mem_wb_ready;
  logic [4:0]  alu_wb_rd, mem_wb_rd;
  logic [31:0] alu_wb_data, mem_wb_data;
  logic        scrub_busy, scrub_done, write_reg;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   done_count = 0;

  rf_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_ready  (alu_wb_ready),
    .alu_wb_rd     (alu_wb_rd),
    .alu_wb_data   (alu_wb_data),
    .mem_wb_valid  (mem_wb_valid),
    .mem_wb_ready  (mem_wb_ready),
    .mem_wb_rd     (mem_wb_rd),
    .mem_wb_data   (mem_wb_data),
    .scrub_start   (scrub_start),
    .scrub_busy    (scrub_busy),
    .scrub_done    (scrub_done),
    .write_reg     (write_reg),
    .target_reg    (target_reg),
    .write_rd_data (write_rd_data)
  );

  always #5 clk = ~clk;

  // Cycle number advances on every rising edge.
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.cyc  = c;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor: compare every presented write against the scoreboard head.
  always @(negedge clk) begin
    if (scrub_done) done_count = done_count + 1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missed_write: rd %0d never written, expected in cycle %0d", q[0].rd, q[0].cyc);
      void'(q.pop_front());
    end
    if (write_reg) begin
      checks = checks + 1;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: rd %0d data %0h in cycle %0d", target_reg, write_rd_data, cyc);
      end else begin
        chk("wb_target", 32'(target_reg), 32'(q[0].rd));
        chk("wb_data", write_rd_data, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    int done_before;
    rst          = 1'b1;
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    scrub_start  = 1'b0;
    alu_wb_rd    = '0;
    alu_wb_data  = '0;
    mem_wb_rd    = '0;
    mem_wb_data  = '0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_target", 32'(target_reg), 0);
    chk("rst_data", write_rd_data, 0);
    chk("rst_busy", 32'(scrub_busy), 0);
    chk("rst_done", 32'(scrub_done), 0);
    chk("rst_alu_ready", 32'(alu_wb_ready), 0);
    chk("rst_mem_ready", 32'(mem_wb_ready), 0);
    tick();
    rst = 1'b0;

    // Single ALU request: output one cycle after the handshake
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
    push(cyc + 1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("single_alu_ready", 32'(alu_wb_ready), 1);
    tick();
    alu_wb_valid = 1'b0;

    // Contention for three cycles (mem rd=3, alu rd=4)
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'h0000_0333;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd4; alu_wb_data = 32'h0000_0444;
    for (int i = 0; i < 3; i++) begin
`ifdef RF_WB_RR_EN
      logic mem_win;
      mem_win = (i != 1);
`else
      logic mem_win;
      mem_win = 1'b1;
`endif
      if (mem_win) push(cyc + 1, 5'd3, 32'h0000_0333);
      else         push(cyc + 1, 5'd4, 32'h0000_0444);
      @(negedge clk);
      chk("contend_mem_ready", 32'(mem_wb_ready), 32'(mem_win));
      chk("contend_alu_ready", 32'(alu_wb_ready), 32'(!mem_win));
      tick();
    end
    mem_wb_valid = 1'b0;
    alu_wb_valid = 1'b0;

    // Write to x0: handshake completes, no write reaches the file
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'h0000_1234;
    @(negedge clk);
    chk("x0_mem_ready", 32'(mem_wb_ready), 1);
    tick();
    mem_wb_valid = 1'b0;
    @(negedge clk);
    chk("x0_write_reg", 32'(write_reg), 0);
    tick();

    // Scrub with both requesters held valid, alu valid in the start cycle
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd8; mem_wb_data = 32'h0000_0088;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h0000_0077;
    scrub_start  = 1'b1;
    c = cyc;
    for (int k = 1; k <= 31; k++) push(c + 1 + k, 5'(k), 32'h0);
    @(negedge clk);
    chk("start_alu_ready", 32'(alu_wb_ready), 0);
    chk("start_mem_ready", 32'(mem_wb_ready), 0);
    tick();
    scrub_start = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      // A restart request mid-sweep must be ignored.
      scrub_start = (j == 15);
      @(negedge clk);
      chk("scrub_busy", 32'(scrub_busy), 1);
      chk("scrub_no_ready", 32'(alu_wb_ready | mem_wb_ready), 0);
      if (j == 31) chk("scrub_done_early", 32'(scrub_done), 0);
      tick();
      scrub_start = 1'b0;
    end
    // Cycle S+32: last scrub write, done pulse, arbitration resumes
    @(negedge clk);
    chk("end_busy", 32'(scrub_busy), 0);
    chk("end_done", 32'(scrub_done), 1);
`ifdef RF_WB_RR_EN
    chk("end_alu_ready", 32'(alu_wb_ready), 1);
    push(cyc + 1, 5'd7, 32'h0000_0077);
`else
    chk("end_mem_ready", 32'(mem_wb_ready), 1);
    push(cyc + 1, 5'd8, 32'h0000_0088);
`endif
    tick();
    mem_wb_valid = 1'b0;
    alu_wb_valid = 1'b0;
    repeat (2) tick();

    // Reset mid-scrub at index 10
    done_before = done_count;
    scrub_start = 1'b1;
    c = cyc;
    for (int k = 1; k <= 10; k++) push(c + 1 + k, 5'(k), 32'h0);
    tick();
    scrub_start = 1'b0;
    while (cyc < c + 11) tick();
    @(negedge clk);
    chk("pre_rst_target", 32'(target_reg), 10);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_write_reg", 32'(write_reg), 0);
    chk("midrst_target", 32'(target_reg), 0);
    chk("midrst_busy", 32'(scrub_busy), 0);
    tick();
    rst = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'hCAFE_F00D;
    push(cyc + 1, 5'd9, 32'hCAFE_F00D);
    @(negedge clk);
    chk("post_rst_alu_ready", 32'(alu_wb_ready), 1);
    tick();
    alu_wb_valid = 1'b0;
    repeat (40) tick();
    chk("no_done_after_rst", done_count - done_before, 0);
    chk("done_pulse_count", done_count, 1);
    chk("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
